mul16_colseq_ctrl: RTL and testbench

MUL16_COLSEQ_CTRL -- requirements
Module: mul16_colseq_ctrl

---
 rtl/mul16_colseq_ctrl_if.sv | 39 +++
 rtl/mul16_colseq_ctrl.sv | 152 +++++++++++++++
 tb/tb_mul16_colseq_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mul16_colseq_ctrl_if.sv
// Handshake and data bundle for mul16_colseq_ctrl.
//
// Purpose: groups the operand/config input channel, the product output
// channel and the status outputs of the column-sequential multiplier.
//
// Signals:
//   in_valid, in_ready   operand channel handshake
//   in_a, in_b           16-bit unsigned operands
//   cfg_trunc            number of low product columns dropped (0..15)
//   out_valid, out_ready product channel handshake
//   out_p                32-bit product
//   busy                 high while an operation is running or held in DONE
//   col_idx              column being compressed, 0 outside RUN
//
// Modports:
//   slave  - the multiplier side
//   master - the producer/consumer side (testbench or upstream logic)
interface mul16_colseq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [3:0]  cfg_trunc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_p;
    logic        busy;
    logic [4:0]  col_idx;

    modport slave (
        input  in_valid, in_a, in_b, cfg_trunc, out_ready,
        output in_ready, out_valid, out_p, busy, col_idx
    );

    modport master (
        output in_valid, in_a, in_b, cfg_trunc, out_ready,
        input  in_ready, out_valid, out_p, busy, col_idx
    );
endinterface

// File: rtl/mul16_colseq_ctrl.sv
// Column-sequential 16x16 unsigned multiplier with optional low-column
// truncation for approximate products.
//
// Purpose: after accepting an operand pair, the block compresses one
// product column per cycle (columns 0..31). Each column's partial-product
// bits are counted, added to the carry from the previous column, the LSB
// becomes the product bit and the remaining bits become the next carry.
// Columns below cfg_trunc contribute nothing, which gives a cheap
// approximate result. The product is held in DONE until consumed.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   io     mul16_colseq_ctrl_if.slave (operand/product handshakes, status)
//
// Parameter:
//   W      operand width; only 16 is supported
module mul16_colseq_ctrl #(
    parameter int W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mul16_colseq_ctrl_if.slave    io
);

    // The column datapath is hard-wired for 16-bit operands.
    if (W != 16) begin : g_width_check
        $error("mul16_colseq_ctrl: only W=16 is supported");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [3:0]  trunc_q, trunc_d;
    logic [4:0]  col_q, col_d;
    logic [3:0]  carry_q, carry_d;
    logic [31:0] prod_q, prod_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;

    logic [4:0]  h;
    logic [4:0]  s;
    logic [4:0]  j_idx;

    // Column compressor: h counts a[i]&b[j] with i+j == col. Column 31 has
    // no pairs (max i+j is 30), so it naturally carries only the carry in.
    // h <= 16 and carry <= 15, so s always fits in 5 bits.
    always_comb begin
        h     = '0;
        j_idx = '0;
        for (int i = 0; i < 16; i++) begin
            j_idx = col_q - 5'(i);
            if ((col_q >= 5'(i)) && (j_idx <= 5'd15)) begin
                h = h + {4'b0000, a_q[i] & b_q[j_idx[3:0]]};
            end
        end
        if ({1'b0, trunc_q} > col_q) begin
            h = '0;
        end
        s = h + {1'b0, carry_q};
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        trunc_d = trunc_q;
        col_d   = col_q;
        carry_d = carry_q;
        prod_d  = prod_q;

        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    a_d     = io.in_a;
                    b_d     = io.in_b;
                    trunc_d = io.cfg_trunc;
                    col_d   = '0;
                    carry_d = '0;
                    prod_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                prod_d[col_q] = s[0];
                carry_d       = s[4:1];
                // The counter never wraps: after the last column it parks at 0.
                if (col_q == 5'd31) begin
                    col_d   = '0;
                    state_d = DONE;
                end else begin
                    col_d = col_q + 5'd1;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line
        // up exactly with the state register.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            trunc_q     <= '0;
            col_q       <= '0;
            carry_q     <= '0;
            prod_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            trunc_q     <= trunc_d;
            col_q       <= col_d;
            carry_q     <= carry_d;
            prod_q      <= prod_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_p     = prod_q;
    assign io.busy      = busy_q;
    assign io.col_idx   = col_q;

endmodule

// File: tb/tb_mul16_colseq_ctrl.sv
// Self-checking testbench for mul16_colseq_ctrl.
//
// Purpose: drives a table of operand/config vectors plus hand-written
// sequences for backpressure and mid-operation reset. Expected products
// are pushed to a scoreboard queue at accept time and popped when the
// block presents a result.
module tb_mul16_colseq_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mul16_colseq_ctrl_if ifc ();

    mul16_colseq_ctrl #(.W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (ifc.slave)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  t;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    // Reference: sum of the partial products whose weight i+j reaches the
    // truncation threshold. Dropped columns produce no carry, so this is
    // exactly the approximate product.
    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] t);
        logic [63:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                if (a[i] && b[j] && ((i + j) >= int'(t))) begin
                    acc = acc + (64'd1 << (i + j));
                end
            end
        end
        return acc[31:0];
    endfunction

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge. Waits for in_ready, presents one operand pair,
    // and returns at the negedge after the accepting edge with the inputs
    // scrambled so late changes would corrupt a non-latched result.
    task automatic accept(input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] t, input logic [31:0] exp,
                          input bit push);
        int guard;
        guard = 0;
        while (!ifc.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!ifc.in_ready) begin
            check_output("in_ready_timeout", 32'(ifc.in_ready), 32'd1);
            return;
        end
        ifc.in_valid  = 1'b1;
        ifc.in_a      = a;
        ifc.in_b      = b;
        ifc.cfg_trunc = t;
        if (push) sb.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid  = 1'b0;
        ifc.in_a      = 16'($urandom);
        ifc.in_b      = 16'($urandom);
        ifc.cfg_trunc = 4'($urandom);
        check_output("accept_busy", 32'(ifc.busy), 32'd1);
    endtask

    // Called at the negedge right after the accepting edge. Counts edges
    // until out_valid and tracks col_idx along the way.
    task automatic wait_done(input int exp_lat);
        int cnt;
        bit col_ok;
        cnt    = 0;
        col_ok = 1'b1;
        while (!ifc.out_valid && cnt < 100) begin
            if (ifc.col_idx !== 5'(cnt)) col_ok = 1'b0;
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        check_output("done_reached", 32'(ifc.out_valid), 32'd1);
        if (exp_lat >= 0) begin
            check_output("latency", 32'(cnt), 32'(exp_lat));
            check_output("col_idx_seq", 32'(col_ok), 32'd1);
        end
        check_output("col_idx_done", 32'(ifc.col_idx), 32'd0);
    endtask

    // Called at a negedge with out_valid high and out_ready high.
    task automatic take_result();
        logic [31:0] exp;
        check_output("no_turnaround", 32'(ifc.in_ready), 32'd0);
        if (sb.size() == 0) begin
            check_output("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            exp = sb.pop_front();
            check_output("out_p", ifc.out_p, exp);
        end
        @(posedge clk);
        @(negedge clk);
        check_output("out_valid_drop", 32'(ifc.out_valid), 32'd0);
        check_output("in_ready_back", 32'(ifc.in_ready), 32'd1);
    endtask

    task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b,
                                  input logic [3:0] t, input logic [31:0] exp);
        ifc.out_ready = 1'b1;
        accept(a, b, t, exp, 1'b1);
        wait_done(32);
        take_result();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   guard;
        bit   stale;

        ifc.in_valid  = 1'b0;
        ifc.in_a      = '0;
        ifc.in_b      = '0;
        ifc.cfg_trunc = '0;
        ifc.out_ready = 1'b1;

        vecs[0] = '{16'hFFFF, 16'hFFFF, 4'd0,  32'hFFFE0001};
        vecs[1] = '{16'h1234, 16'h5678, 4'd0,  32'h06260060};
        vecs[2] = '{16'h000F, 16'h000F, 4'd4,  32'h000000B0};
        vecs[3] = '{16'h0000, 16'hFFFF, 4'd0,  32'h00000000};
        vecs[4] = '{16'h8000, 16'h8000, 4'd0,  32'h40000000};
        vecs[5] = '{16'hA5A5, 16'h5A5A, 4'd15, model(16'hA5A5, 16'h5A5A, 4'd15)};
        for (int k = 6; k < 10; k++) begin
            vecs[k].a   = 16'($urandom);
            vecs[k].b   = 16'($urandom);
            vecs[k].t   = (k == 6) ? 4'd0 : 4'($urandom_range(0, 15));
            vecs[k].exp = model(vecs[k].a, vecs[k].b, vecs[k].t);
        end

        // Reset state while rst_n is held low.
        #12;
        check_output("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check_output("rst_busy",      32'(ifc.busy),      32'd0);
        check_output("rst_out_p",     ifc.out_p,          32'd0);
        check_output("rst_col_idx",   32'(ifc.col_idx),   32'd0);

        // Release at a negedge; the first vector is accepted on the very
        // next rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("rst_in_ready", 32'(ifc.in_ready), 32'd1);

        foreach (vecs[k]) begin
            apply_stimulus(vecs[k].a, vecs[k].b, vecs[k].t, vecs[k].exp);
        end

        // Backpressure: hold out_ready low 10 cycles in DONE with in_valid
        // high and different operands, then hand over and re-accept.
        ifc.out_ready = 1'b0;
        accept(16'h1234, 16'h5678, 4'd0, 32'h06260060, 1'b1);
        ifc.in_valid = 1'b1;
        ifc.in_a     = 16'hFFFF;
        ifc.in_b     = 16'hFFFF;
        wait_done(32);
        for (int c = 0; c < 10; c++) begin
            check_output("hold_out_p",     ifc.out_p,             32'h06260060);
            check_output("hold_in_ready",  32'(ifc.in_ready),     32'd0);
            check_output("hold_out_valid", 32'(ifc.out_valid),    32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        ifc.in_a      = 16'h8000;
        ifc.in_b      = 16'h8000;
        ifc.cfg_trunc = 4'd0;
        ifc.out_ready = 1'b1;
        take_result();
        check_output("handoff_busy", 32'(ifc.busy), 32'd0);
        sb.push_back(32'h40000000);
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        check_output("reaccept_busy",     32'(ifc.busy),     32'd1);
        check_output("reaccept_in_ready", 32'(ifc.in_ready), 32'd0);
        check_output("reaccept_col_idx",  32'(ifc.col_idx),  32'd0);
        wait_done(32);
        take_result();

        // Asynchronous reset in the middle of RUN at column 12.
        accept(16'hBEEF, 16'hCAFE, 4'd0, 32'd0, 1'b0);
        guard = 0;
        while (ifc.col_idx != 5'd12 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_output("reached_col12", 32'(ifc.col_idx), 32'd12);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_out_valid", 32'(ifc.out_valid), 32'd0);
        check_output("async_busy",      32'(ifc.busy),      32'd0);
        check_output("async_out_p",     ifc.out_p,          32'd0);
        check_output("async_col_idx",   32'(ifc.col_idx),   32'd0);
        check_output("async_in_ready",  32'(ifc.in_ready),  32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ifc.out_valid || ifc.busy) stale = 1'b1;
        end
        check_output("no_stale_valid", 32'(stale), 32'd0);
        apply_stimulus(16'h1234, 16'h5678, 4'd0, 32'h06260060);

        // Reset again, then accept on the first edge after release.
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(16'h000F, 16'h000F, 4'd4, 32'h000000B0);

        check_output("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
